// File: rtl/ahb_lite_sram_slave.sv
// AHB-Lite slave for on-chip word-organised SRAM with programmable wait states and write-to-read forwarding.
// Define SRAM_SLAVE_ERR_EN to answer out-of-range, misaligned and oversized transfers with ERROR.
module ahb_lite_sram_slave #(
    parameter int unsigned ADDR_WIDTH  = 12,
    parameter logic [31:0] BASE_ADDR   = 32'h2000_0000,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [1:0]  HTRANS,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic        HREADYOUT,
    output logic [31:0] HRDATA,
    output logic [1:0]  HRESP
);

    localparam int unsigned DEPTH   = 1 << ADDR_WIDTH;
    localparam int unsigned CNT_W   = 2;
    localparam int unsigned TAG_LSB = ADDR_WIDTH + 2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ERR1 = 2'd2,
        S_ERR2 = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    hreadyout_q;
    logic                    hresp_q;
    logic [31:0]             hrdata_q;
    logic                    valid_q;
    logic                    write_q;
    logic [ADDR_WIDTH-1:0]   idx_q;
    logic [3:0]              lanes_q;

    logic                    take_c;
    logic                    err_c;
    logic                    commit_c;
    logic [3:0]              lanes_c;
    logic [ADDR_WIDTH-1:0]   rd_idx_c;
    logic [31:0]             wr_word_c;
    logic [31:0]             rd_word_c;
    logic                    unused_c;

    logic [31:0] mem [DEPTH];

    assign take_c   = HSEL && HREADY && HTRANS[1] && hreadyout_q;
    assign rd_idx_c = HADDR[ADDR_WIDTH+1:2];
    assign commit_c = valid_q && write_q && hreadyout_q;
    assign unused_c = ^{HTRANS[0], HADDR[31:TAG_LSB], BASE_ADDR};

`ifdef SRAM_SLAVE_ERR_EN
    assign err_c = (HADDR[31:TAG_LSB] != BASE_ADDR[31:TAG_LSB])
                || (HSIZE > 3'd2)
                || ((HSIZE == 3'd1) && HADDR[0])
                || ((HSIZE == 3'd2) && (HADDR[1:0] != 2'b00));
`else
    assign err_c = 1'b0;
`endif

    // Byte lanes; low address bits beyond the transfer size are ignored.
    always_comb begin
        lanes_c = 4'b1111;
        case (HSIZE)
            3'd0:    lanes_c = 4'b0001 << HADDR[1:0];
            3'd1:    lanes_c = HADDR[1] ? 4'b1100 : 4'b0011;
            default: lanes_c = 4'b1111;
        endcase
    end

    // Merged write word, forwarded to a read of the same word accepted on the commit edge.
    always_comb begin
        wr_word_c = mem[idx_q];
        for (int b = 0; b < 4; b++) begin
            if (lanes_q[b]) wr_word_c[8*b +: 8] = HWDATA[8*b +: 8];
        end
        rd_word_c = (commit_c && (idx_q == rd_idx_c)) ? wr_word_c : mem[rd_idx_c];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE, S_ERR2: begin
                state_d = S_IDLE;
                if (take_c) begin
                    if (err_c) begin
                        state_d = S_ERR1;
                    end else if (WAIT_STATES != 32'd0) begin
                        state_d = S_WAIT;
                        cnt_d   = CNT_W'(WAIT_STATES);
                    end
                end
            end
            S_WAIT: begin
                cnt_d = CNT_W'(cnt_q - 2'd1);
                if (cnt_q == 2'd1) state_d = S_IDLE;
            end
            S_ERR1:  state_d = S_ERR2;
            default: state_d = S_IDLE;
        endcase
    end

    // Registered bus outputs and the address-phase capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hreadyout_q <= 1'b1;
            hresp_q     <= 1'b0;
            hrdata_q    <= '0;
            valid_q     <= 1'b0;
            write_q     <= 1'b0;
            idx_q       <= '0;
            lanes_q     <= '0;
        end else begin
            hreadyout_q <= (state_d == S_IDLE) || (state_d == S_ERR2);
            hresp_q     <= (state_d == S_ERR1) || (state_d == S_ERR2);
            if (hreadyout_q) begin
                valid_q <= take_c && !err_c;
                if (take_c) begin
                    write_q <= HWRITE;
                    idx_q   <= rd_idx_c;
                    lanes_q <= lanes_c;
                end
            end
            if (take_c && !HWRITE && !err_c) hrdata_q <= rd_word_c;
        end
    end

    always_ff @(posedge clk) begin
        if (commit_c) mem[idx_q] <= wr_word_c;
    end

    assign HREADYOUT = hreadyout_q;
    assign HRDATA    = hrdata_q;
    assign HRESP     = {1'b0, hresp_q};

endmodule

// File: doc/ahb_lite_sram_slave.md
Name: ahb_lite_sram_slave

Overview:
- AHB-Lite slave holding on-chip word-organised SRAM, placed downstream of the AHB-Lite master mux.
- Serves fetches and loads/stores from the M0 core and debug/program-load writes from the UART debugger.
- Decodes byte/halfword/word transfers and inserts programmable wait states.
- Forwards write data to an immediately following read of the same word.

Parameters:
ADDR_WIDTH, 12, word-address bits; memory depth 2**ADDR_WIDTH words (16 KB default)
BASE_ADDR, 32'h2000_0000, byte base address of the region; must be aligned to 4*2**ADDR_WIDTH
WAIT_STATES, 0, data-phase wait cycles per OKAY transfer, legal 0..3

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
HSEL  input  1  slave select from bus decoder
HADDR  input  32  address-phase byte address
HWRITE  input  1  1=write, 0=read
HSIZE  input  3  0=byte, 1=halfword, 2=word
HTRANS  input  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
HWDATA  input  32  write data, valid in the data phase
HREADY  input  1  bus-level ready; address phase sampled only when high
HREADYOUT  output  1  slave ready
HRDATA  output  32  read data
HRESP  output  2  00 OKAY, 01 ERROR; bit 1 tied 0

Behaviour:
- Accept: HSEL & HREADY & HTRANS[1] at a rising edge. Register addr, write, size and a valid flag.
- IDLE/BUSY or unselected: no data phase; zero-wait OKAY.
- Reset (async, any time): state IDLE, HREADYOUT=1, HRESP=00, HRDATA=0, registered valid=0. Memory contents are not cleared. A transfer in flight at reset is dropped and no write occurs.
- FSM states:
  - IDLE: HREADYOUT=1. On an accepted OKAY transfer with WAIT_STATES>0, load counter=WAIT_STATES and go to WAIT. With WAIT_STATES=0, remain in IDLE/data phase.
  - WAIT: HREADYOUT=0; counter decrements each cycle; at counter==1 go to IDLE (data phase completes next cycle with HREADYOUT=1).
  - ERR1: HREADYOUT=0, HRESP=01; always go to ERR2.
  - ERR2: HREADYOUT=1, HRESP=01; go to IDLE, or accept a new transfer this cycle.
- Latency: an OKAY data phase lasts exactly WAIT_STATES+1 cycles. Error transfers skip wait states and always last 2 cycles.
- Byte lanes (little-endian):
  - size 0: lane HADDR[1:0].
  - size 1: lanes {HADDR[1],0} and {HADDR[1],1}.
  - size 2: all four lanes.
- Write commit: on the edge ending the write data phase (HREADYOUT=1). Only the selected lanes of mem[addr[ADDR_WIDTH+1:2]] are updated from HWDATA.
- Read data: HRDATA is driven in the read data phase and is valid when HREADYOUT=1. It holds the last read value otherwise.
- Read-after-write: a read accepted on the same edge that commits a write to the same word returns the merged (post-write) word, with no extra wait.
- Back-to-back: a new address phase may be accepted on the final cycle of any data phase, including ERR2.
- Word index: addr[ADDR_WIDTH+1:2].
- Out-of-range handling: see Optional Feature.

Optional Feature:
Macro SRAM_SLAVE_ERR_EN.
- Defined: an accepted transfer produces ERR1→ERR2 and no memory write if any of these hold:
  - address outside [BASE_ADDR, BASE_ADDR+4*2**ADDR_WIDTH);
  - misaligned (size 1 with HADDR[0]=1, or size 2 with HADDR[1:0]!=0);
  - HSIZE>2.
- Undefined: no ERROR ever; HRESP constant 00.
  - The address is masked to the word index, so out-of-range accesses alias.
  - HSIZE>2 is treated as a word access.
  - Misaligned lanes follow the lane rule with the low bits that are ignored for that size forced to zero.

Test Plan:
- WAIT_STATES=0: write word 0xDEADBEEF at 0x2000_0010, then read 0x2000_0010 → HRDATA=0xDEADBEEF, HREADYOUT never low, HRESP=00.
- Byte write 0xA5 to 0x2000_0013 after case 1; read word 0x2000_0010 → 0xA5ADBEEF. Halfword write 0x1234 to 0x2000_0010 → 0xA5AD1234.
- NONSEQ write 0x11223344 to 0x2000_0020 immediately followed by NONSEQ read of 0x2000_0020 (read address phase = write data phase) → read returns 0x11223344 with zero waits.
- WAIT_STATES=2: read 0x2000_0010 → HREADYOUT low exactly 2 cycles, high on the 3rd with correct data. Back-to-back read also shows exactly 2 low cycles.
- SRAM_SLAVE_ERR_EN defined: word write at 0x2000_0002 or 0x3000_0000 → HREADYOUT 0/HRESP 01, then 1/01; memory unchanged. Undefined: same write → OKAY, stores aliased word 0x2000_0000.
- Assert rst_n low during WAIT of a write → HREADYOUT=1, HRESP=00, HRDATA=0 asynchronously; target word retains its old value.
